// File: rtl/control_unit_tpu.sv
// Instruction sequencer for the TPU datapath: samples one instruction per period and drives buffer/FIFO/systolic strobes.
// Define CU_OPCODE_CHECK_EN to make unknown opcodes (7-15) a visible 2-cycle trap instead of plain IDLE timing.
module control_unit_tpu #(
    parameter int IDLE_CYCLE         = 1,
    parameter int WRITE_WEIGHT_CYCLE = 1,
    parameter int LOAD_DATA_CYCLE    = 1,
    parameter int LOAD_WEIGHT_CYCLE  = 1,
    parameter int MAT_MUL_CYCLE      = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [147:0] instruction,
    output logic         flag,
    output logic         write_ub,
    output logic         read_ub,
    output logic         write_wb,
    output logic         read_wb,
    output logic         write_acc,
    output logic         read_acc,
    output logic         data_fifo_en,
    output logic         weight_fifo_en,
    output logic         mm_en,
    output logic         acc_en,
    output logic [7:0]   addra,
    output logic [7:0]   addrb,
    output logic [319:0] dout
);
    localparam int CW = 16;

`ifdef CU_OPCODE_CHECK_EN
    localparam int TRAP_CYCLE = 2;
`else
    localparam int TRAP_CYCLE = IDLE_CYCLE;
`endif

    typedef enum logic [3:0] {
        OP_IDLE      = 4'd0,
        OP_WR_DATA   = 4'd1,
        OP_WR_WEIGHT = 4'd2,
        OP_LD_DATA   = 4'd3,
        OP_LD_WEIGHT = 4'd4,
        OP_MM        = 4'd5,
        OP_MM_ACC    = 4'd6
    } op_e;

    function automatic logic [CW-1:0] period_of(input logic [3:0] o);
        case (o)
            4'd0, 4'd1: period_of = CW'(IDLE_CYCLE);
            4'd2:       period_of = CW'(WRITE_WEIGHT_CYCLE);
            4'd3:       period_of = CW'(LOAD_DATA_CYCLE);
            4'd4:       period_of = CW'(LOAD_WEIGHT_CYCLE);
            4'd5, 4'd6: period_of = CW'(MAT_MUL_CYCLE);
            default:    period_of = CW'(TRAP_CYCLE);
        endcase
    endfunction

    logic [3:0]    opc;
    logic [CW-1:0] period;
    assign opc    = instruction[147:144];
    assign period = period_of(opc);

    op_e           op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    lat_addra_q, lat_addra_d;
    logic          flag_q, flag_d;
    logic          write_ub_q, write_ub_d, read_ub_q, read_ub_d;
    logic          write_wb_q, write_wb_d, read_wb_q, read_wb_d;
    logic          write_acc_q, write_acc_d;
    logic          data_fifo_en_q, data_fifo_en_d, weight_fifo_en_q, weight_fifo_en_d;
    logic          mm_en_q, mm_en_d, acc_en_q, acc_en_d;
    logic [7:0]    addra_q, addra_d, addrb_q, addrb_d;
    logic [319:0]  dout_q, dout_d;

    always_comb begin
        op_d             = op_q;
        cnt_d            = cnt_q;
        lat_addra_d      = lat_addra_q;
        flag_d           = flag_q;
        write_ub_d       = 1'b0;
        read_ub_d        = 1'b0;
        write_wb_d       = 1'b0;
        read_wb_d        = 1'b0;
        write_acc_d      = 1'b0;
        data_fifo_en_d   = 1'b0;
        weight_fifo_en_d = 1'b0;
        mm_en_d          = 1'b0;
        acc_en_d         = 1'b0;
        addra_d          = addra_q;
        addrb_d          = addrb_q;
        dout_d           = dout_q;
        if (cnt_q == '0) begin
            // Sampling edge: start cycle 0 of a new execution.
            cnt_d       = period - CW'(1);
            flag_d      = (cnt_d == '0);
            lat_addra_d = instruction[143:136];
            op_d        = (opc <= 4'd6) ? op_e'(opc) : OP_IDLE;
            case (opc)
                4'd1: begin
                    write_ub_d = 1'b1;
                    addra_d    = instruction[143:136];
                    dout_d     = {192'b0, instruction[127:0]};
                end
                4'd2: begin
                    write_wb_d = 1'b1;
                    addra_d    = instruction[143:136];
                    dout_d     = {192'b0, instruction[127:0]};
                end
                4'd3: begin
                    read_ub_d      = 1'b1;
                    data_fifo_en_d = 1'b1;
                    addrb_d        = instruction[135:128];
                end
                4'd4: begin
                    read_wb_d        = 1'b1;
                    weight_fifo_en_d = 1'b1;
                    addrb_d          = instruction[135:128];
                end
                4'd5, 4'd6: mm_en_d = 1'b1;
                default: ;
            endcase
        end else begin
            cnt_d  = cnt_q - CW'(1);
            flag_d = (cnt_d == '0);
            if (op_q == OP_MM || op_q == OP_MM_ACC) begin
                if (cnt_d != '0) begin
                    mm_en_d = 1'b1;
                end else begin
                    // Last cycle of the multiply: commit results to the accumulator.
                    write_acc_d = 1'b1;
                    addra_d     = lat_addra_q;
                    acc_en_d    = (op_q == OP_MM_ACC);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q             <= OP_IDLE;
            cnt_q            <= '0;
            lat_addra_q      <= '0;
            flag_q           <= 1'b1;
            write_ub_q       <= 1'b0;
            read_ub_q        <= 1'b0;
            write_wb_q       <= 1'b0;
            read_wb_q        <= 1'b0;
            write_acc_q      <= 1'b0;
            data_fifo_en_q   <= 1'b0;
            weight_fifo_en_q <= 1'b0;
            mm_en_q          <= 1'b0;
            acc_en_q         <= 1'b0;
            addra_q          <= '0;
            addrb_q          <= '0;
            dout_q           <= '0;
        end else begin
            op_q             <= op_d;
            cnt_q            <= cnt_d;
            lat_addra_q      <= lat_addra_d;
            flag_q           <= flag_d;
            write_ub_q       <= write_ub_d;
            read_ub_q        <= read_ub_d;
            write_wb_q       <= write_wb_d;
            read_wb_q        <= read_wb_d;
            write_acc_q      <= write_acc_d;
            data_fifo_en_q   <= data_fifo_en_d;
            weight_fifo_en_q <= weight_fifo_en_d;
            mm_en_q          <= mm_en_d;
            acc_en_q         <= acc_en_d;
            addra_q          <= addra_d;
            addrb_q          <= addrb_d;
            dout_q           <= dout_d;
        end
    end

    assign flag           = flag_q;
    assign write_ub       = write_ub_q;
    assign read_ub        = read_ub_q;
    assign write_wb       = write_wb_q;
    assign read_wb        = read_wb_q;
    assign write_acc      = write_acc_q;
    assign read_acc       = 1'b0;
    assign data_fifo_en   = data_fifo_en_q;
    assign weight_fifo_en = weight_fifo_en_q;
    assign mm_en          = mm_en_q;
    assign acc_en         = acc_en_q;
    assign addra          = addra_q;
    assign addrb          = addrb_q;
    assign dout           = dout_q;
endmodule

// File: tb/tb_control_unit_tpu.sv
// Randomized bench for control_unit_tpu against a cycle-indexed behavioural model of the instruction schedule.
module tb_control_unit_tpu;
    logic         clk = 1'b0;
    logic         reset;
    logic [147:0] instruction;
    logic         flag, write_ub, read_ub, write_wb, read_wb, write_acc, read_acc;
    logic         data_fifo_en, weight_fifo_en, mm_en, acc_en;
    logic [7:0]   addra, addrb;
    logic [319:0] dout;

    control_unit_tpu dut (
        .clk(clk), .reset(reset), .instruction(instruction), .flag(flag),
        .write_ub(write_ub), .read_ub(read_ub), .write_wb(write_wb), .read_wb(read_wb),
        .write_acc(write_acc), .read_acc(read_acc), .data_fifo_en(data_fifo_en),
        .weight_fifo_en(weight_fifo_en), .mm_en(mm_en), .acc_en(acc_en),
        .addra(addra), .addrb(addrb), .dout(dout)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Model state: position k within an execution of period n.
    int         m_k, m_n;
    logic [3:0] m_op;
    logic [7:0] m_a, m_b;
    logic [127:0] m_opnd;
    logic       e_flag;
    logic [9:0] e_str; // {wub,rub,wwb,rwb,wacc,racc,dfe,wfe,mm,acc}
    logic [7:0] e_addra, e_addrb;
    logic [319:0] e_dout;

    function automatic int period(input logic [3:0] o);
        case (o)
            4'd0, 4'd1: return 1;
            4'd2, 4'd3, 4'd4: return 1;
            4'd5, 4'd6: return 32;
`ifdef CU_OPCODE_CHECK_EN
            default: return 2;
`else
            default: return 1;
`endif
        endcase
    endfunction

    task automatic model_edge();
        if (reset) begin
            e_flag = 1'b1; e_str = '0; e_addra = '0; e_addrb = '0; e_dout = '0;
            m_k = 0; m_n = 1; m_op = 4'd0;
        end else begin
            if (e_flag) begin
                m_op = instruction[147:144]; m_a = instruction[143:136];
                m_b = instruction[135:128]; m_opnd = instruction[127:0];
                m_n = period(m_op); m_k = 0;
            end else begin
                m_k++;
            end
            e_flag = (m_k == m_n - 1);
            e_str = '0;
            case (m_op)
                4'd1: if (m_k == 0) begin e_str[9] = 1; e_addra = m_a; e_dout = {192'b0, m_opnd}; end
                4'd2: if (m_k == 0) begin e_str[7] = 1; e_addra = m_a; e_dout = {192'b0, m_opnd}; end
                4'd3: if (m_k == 0) begin e_str[8] = 1; e_str[3] = 1; e_addrb = m_b; end
                4'd4: if (m_k == 0) begin e_str[6] = 1; e_str[2] = 1; e_addrb = m_b; end
                4'd5, 4'd6: begin
                    if (m_k < m_n - 1) e_str[1] = 1;
                    else begin e_str[5] = 1; e_addra = m_a; e_str[0] = (m_op == 4'd6); end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("flag", 320'(flag), 320'(e_flag));
        chk("strobes", 320'({write_ub, read_ub, write_wb, read_wb, write_acc, read_acc,
                             data_fifo_en, weight_fifo_en, mm_en, acc_en}), 320'(e_str));
        chk("addra", 320'(addra), 320'(e_addra));
        chk("addrb", 320'(addrb), 320'(e_addrb));
        chk("dout", dout, e_dout);
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [127:0] opnd, input int cyc);
        instruction = {op, a, b, opnd};
        for (int i = 0; i < cyc; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [127:0] pat;
        reset = 1'b1;
        instruction = '0;
        e_flag = 1'b1;
        do_reset();
        issue(4'd0, 8'd0, 8'd0, '0, 2);
        for (int i = 0; i < 16; i++) pat[i*8 +: 8] = 8'(5 - i);
        issue(4'd1, 8'd5, 8'd0, pat, 1);
        issue(4'd0, 8'd0, 8'd0, '0, 2);
        for (int i = 0; i < 5; i++) issue(4'd3, 8'd0, 8'(i), '0, 1);
        for (int i = 0; i < 21; i++) issue(4'd4, 8'd0, 8'(i), '0, 1);
        issue(4'd5, 8'd3, 8'd0, '0, 32);
        issue(4'd0, 8'd0, 8'd0, '0, 1);
        issue(4'd6, 8'd4, 8'd0, '0, 32);
        issue(4'd0, 8'd0, 8'd0, '0, 1);
        issue(4'd5, 8'd9, 8'd0, '0, 11);
        do_reset();
        issue(4'd0, 8'd0, 8'd0, '0, 3);
        issue(4'd9, 8'd7, 8'd7, '1, 4);
        issue(4'd6, 8'd2, 8'd0, '0, 70);
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            pat = {$urandom, $urandom, $urandom, $urandom};
            issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), pat,
                  $urandom_range(1, 40));
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/control_unit_tpu.md
CONTROL_UNIT_TPU -- requirements
Module: control_unit_tpu

Interface
REQ-001 SHALL have parameters (name, default, meaning): IDLE_CYCLE, 1, period of IDLE and WRITE_DATA; WRITE_WEIGHT_CYCLE, 1, period of WRITE_WEIGHT; LOAD_DATA_CYCLE, 1, period of LOAD_DATA; LOAD_WEIGHT_CYCLE, 1, period of LOAD_WEIGHT; MAT_MUL_CYCLE, 32, period of MAT_MUL/MAT_MUL_ACC (minimum 2).
REQ-002 SHALL have one clock, and reset SHALL be synchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port instruction, input, 148 bits: opcode [147:144], addra [143:136], addrb [135:128], operand [127:0].
REQ-006 SHALL have port flag, output, 1 bit: ready; the instruction is sampled on the rising edge ending a cycle with flag=1.
REQ-007 SHALL have ports write_ub, read_ub, write_wb, read_wb, write_acc and read_acc, each an output of 1 bit: unified, weight and accumulator buffer strobes (read_acc is tied to 0 and reserved).
REQ-008 SHALL have ports data_fifo_en, weight_fifo_en, mm_en and acc_en, each an output of 1 bit: FIFO push, systolic enable and accumulate mode.
REQ-009 SHALL have ports addra and addrb, each an output of 8 bits: buffer addresses.
REQ-010 SHALL have port dout, output, 320 bits: write data, equal to {192'b0, operand}.

Function
REQ-011 SHALL decode the opcode as follows: 0 IDLE, 1 WRITE_DATA, 2 WRITE_WEIGHT, 3 LOAD_DATA, 4 LOAD_WEIGHT, 5 MAT_MUL, 6 MAT_MUL_ACC, and 7-15 executed as IDLE.
REQ-012 SHALL, on the sampling edge E0, latch the instruction, load the busy counter with N-1 (N = period of the opcode), and drive flag=0 when N>1.
REQ-013 SHALL number cycles as follows: cycle k is the cycle after edge E0+k; the counter decrements each edge; flag=1 when the counter is 0; the next instruction is sampled at edge E_N.
REQ-014 SHALL make all outputs registered, and all strobes not listed below SHALL be 0.
REQ-015 SHALL, for WRITE_DATA, drive in cycle 0 write_ub=1, addra=ADDRA and dout=operand.
REQ-016 SHALL, for WRITE_WEIGHT, drive in cycle 0 write_wb=1, addra=ADDRA and dout=operand.
REQ-017 SHALL, for LOAD_DATA, drive in cycle 0 read_ub=1, data_fifo_en=1 and addrb=ADDRB.
REQ-018 SHALL, for LOAD_WEIGHT, drive in cycle 0 read_wb=1, weight_fifo_en=1 and addrb=ADDRB.
REQ-019 SHALL, for MAT_MUL, drive mm_en=1 in cycles 0..N-2, then in cycle N-1 drive mm_en=0, write_acc=1, addra=ADDRA and acc_en=0.
REQ-020 SHALL execute MAT_MUL_ACC identically to MAT_MUL, except acc_en=1 in cycle N-1.
REQ-021 SHALL, for IDLE, assert no strobes.
REQ-022 SHALL hold addra, addrb and dout at their last values when not updated.
REQ-023 SHALL ignore instruction changes while flag=0.
REQ-024 SHALL re-execute an instruction held past N cycles (a new execution every N cycles).
REQ-025 SHALL, for N=1, keep flag at 1 permanently and sample every edge.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set flag=1, the counter to 0, all strobes to 0, and addra, addrb and dout to 0.
REQ-027 SHALL give reset priority over sampling, so that reset mid-instruction aborts it, including suppressing a pending write_acc.
REQ-028 SHALL sample the first instruction at the first edge with reset=0.

Configuration
REQ-029 SHALL, with macro CU_OPCODE_CHECK_EN defined, decode opcodes 7-15 as IDLE and hold flag=0 for exactly 1 extra cycle after such an instruction (period 2) as a visible trap.
REQ-030 SHALL, without macro CU_OPCODE_CHECK_EN, give opcodes 7-15 IDLE timing (period IDLE_CYCLE).

Verification
REQ-031 SHALL cover: reset asserted for 1 edge, then release -> flag=1, all strobes 0, addra=0, dout=0.
REQ-032 SHALL cover: WRITE_DATA with ADDRA=5 and operand bytes 5,4,...,-10 held 1 cycle -> write_ub=1 for 1 cycle, addra=5, dout[127:0]=operand, dout[319:128]=0.
REQ-033 SHALL cover: LOAD_DATA for ADDRB=0..4, then LOAD_WEIGHT for ADDRB=0..20 -> 5 data_fifo_en pulses followed by 21 weight_fifo_en pulses, each with addrb matching.
REQ-034 SHALL cover: MAT_MUL with ADDRA=3 -> mm_en high 31 cycles, then write_acc=1 with addra=3 and acc_en=0; flag low for 31 cycles.
REQ-035 SHALL cover: MAT_MUL_ACC with ADDRA=4 -> same timing as MAT_MUL, with acc_en=1 in the write_acc cycle.
REQ-036 SHALL cover: reset during cycle 10 of a MAT_MUL -> mm_en drops next cycle, no write_acc pulse, flag=1.
